edge_detect_multi: RTL and testbench

- Multi-channel, parametrised edge detector for asynchronous or noisy 1-bit inputs such as buttons, external strobes and handshake lines.
- Each channel has a configurable-depth synchroniser, a stability (debounce) filter and per-channel mode selection (rise/fall/both/off).
- Outputs per channel: a one-cycle edge pulse and a sticky event flag; a combined interrupt is also produced.
- Sits between raw pins/slow domains and control FSMs that need single-cycle event strobes.

---
 rtl/edge_detect_multi.sv | 105 ++++++++++
 tb/tb_edge_detect_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised, debounced edge detector with per-channel mode,
// one-cycle pulses, sticky flags and a combined registered interrupt.

module edge_detect_lane #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       flag
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   upd;
  logic                   pulse_n;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync <= '0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  // Level commits on the FILT_CYCLES-th consecutive differing sample.
  always_comb begin
    upd     = (s != level) && (cnt == CNT_W'(FILT_CYCLES - 1));
    pulse_n = upd && (s ? mode[0] : mode[1]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
      flag  <= 1'b0;
    end else begin
      if (s == level) begin
        cnt <= '0;
      end else if (upd) begin
        cnt   <= '0;
        level <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
      pulse <= pulse_n;
      // A new event beats a same-cycle clear.
      flag  <= pulse_n | (flag & ~clr);
    end
  end

endmodule

module edge_detect_multi #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WIDTH-1:0]   data,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   flag,
  output logic               irq
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    edge_detect_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk  (clk),
      .n_rst(n_rst),
      .d    (data[g]),
      .mode (mode[2*g +: 2]),
      .clr  (clr[g]),
      .level(level[g]),
      .pulse(pulse[g]),
      .flag (flag[g])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) irq <= 1'b0;
    else        irq <= |(flag & irq_en);
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Scoreboard bench for edge_detect_multi: expected pulse/level events are
// queued when stimulus is driven and popped on the cycle they are due.

module tb_edge_detect_multi;

  logic        clk;
  logic        n_rst;
  logic [7:0]  data;
  logic [15:0] mode;
  logic [7:0]  clr;
  logic [7:0]  irq_en;
  logic [7:0]  level;
  logic [7:0]  pulse;
  logic [7:0]  flag;
  logic        irq;

  typedef struct {
    int         cyc;
    logic [7:0] pulse;
    logic [7:0] level;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  edge_detect_multi dut (
    .clk   (clk),
    .n_rst (n_rst),
    .data  (data),
    .mode  (mode),
    .clr   (clr),
    .irq_en(irq_en),
    .level (level),
    .pulse (pulse),
    .flag  (flag),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (level !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", level); end
    checks++; if (pulse !== 8'h00) begin failures++; $display("FAIL reset_pulse got=%h exp=00", pulse); end
    checks++; if (flag  !== 8'h00) begin failures++; $display("FAIL reset_flag got=%h exp=00", flag); end
    checks++; if (irq   !== 1'b0)  begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  // data held high through reset: one rising pulse per channel after release.
  task automatic test_powerup();
    exp_t e;
    int   e0;
    n_rst = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back('{e0 + 5, 8'hFF, 8'hFF});
    repeat (8) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse !== e.pulse || level !== e.level) begin
          failures++;
          $display("FAIL powerup_edge cyc=%0d pulse=%h level=%h exp pulse=%h level=%h", cyc, pulse, level, e.pulse, e.level);
        end
      end else begin
        checks++;
        if (pulse !== 8'h00) begin failures++; $display("FAIL powerup_idle cyc=%0d pulse=%h exp=00", cyc, pulse); end
      end
    end
    clr = 8'hFF; data = 8'h00;
    @(posedge clk); #1;
    clr = 8'h00;
    checks++; if (flag !== 8'h00) begin failures++; $display("FAIL powerup_clr flag=%h exp=00", flag); end
    repeat (8) begin
      @(posedge clk); #1;
      checks++;
      if (pulse !== 8'h00) begin failures++; $display("FAIL powerup_fall cyc=%0d pulse=%h exp=00", cyc, pulse); end
    end
    checks++; if (level !== 8'h00) begin failures++; $display("FAIL powerup_fall_level got=%h exp=00", level); end
  endtask

  task automatic test_basic();
    exp_t e;
    int   e0;
    irq_en = 8'h01; data[0] = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back('{e0 + 5, 8'h01, 8'h01});
    repeat (8) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse !== e.pulse || level !== e.level) begin
          failures++;
          $display("FAIL basic_edge cyc=%0d pulse=%h level=%h exp pulse=%h level=%h", cyc, pulse, level, e.pulse, e.level);
        end
      end else begin
        checks++;
        if (pulse !== 8'h00) begin failures++; $display("FAIL basic_idle cyc=%0d pulse=%h exp=00", cyc, pulse); end
      end
      if (cyc == e0 + 4) begin
        checks++; if (level !== 8'h00) begin failures++; $display("FAIL basic_early_level got=%h exp=00", level); end
      end
      if (cyc == e0 + 5) begin
        checks++; if (flag !== 8'h01) begin failures++; $display("FAIL basic_flag got=%h exp=01", flag); end
        checks++; if (irq !== 1'b0)   begin failures++; $display("FAIL basic_irq_lag got=%b exp=0", irq); end
      end
      if (cyc == e0 + 6) begin
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq got=%b exp=1", irq); end
      end
    end
    data[0] = 1'b0; clr = 8'h01;
    @(posedge clk); #1;
    clr = 8'h00;
    repeat (8) begin
      @(posedge clk); #1;
      checks++;
      if (pulse !== 8'h00) begin failures++; $display("FAIL basic_fall cyc=%0d pulse=%h exp=00", cyc, pulse); end
    end
    checks++; if (level !== 8'h00 || flag !== 8'h00 || irq !== 1'b0) begin
      failures++; $display("FAIL basic_settle level=%h flag=%h irq=%b exp 00/00/0", level, flag, irq);
    end
    irq_en = 8'h00;
  endtask

  // 3-cycle high is rejected, 4-cycle high is accepted (mode both).
  task automatic test_glitch();
    exp_t e;
    int   e0;
    mode[3:2] = 2'b11; irq_en = 8'h02;
    data[1] = 1'b1;
    e0 = cyc + 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (cyc == e0 + 2) data[1] = 1'b0;
      checks++;
      if (pulse !== 8'h00) begin failures++; $display("FAIL glitch_pulse cyc=%0d pulse=%h exp=00", cyc, pulse); end
    end
    checks++; if (level !== 8'h00 || flag !== 8'h00 || irq !== 1'b0) begin
      failures++; $display("FAIL glitch_state level=%h flag=%h irq=%b exp 00/00/0", level, flag, irq);
    end
    data[1] = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back('{e0 + 5, 8'h02, 8'h02});
    exp_q.push_back('{e0 + 9, 8'h02, 8'h00});
    repeat (13) begin
      @(posedge clk); #1;
      if (cyc == e0 + 3) data[1] = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse !== e.pulse || level !== e.level) begin
          failures++;
          $display("FAIL accept_edge cyc=%0d pulse=%h level=%h exp pulse=%h level=%h", cyc, pulse, level, e.pulse, e.level);
        end
      end else begin
        checks++;
        if (pulse !== 8'h00) begin failures++; $display("FAIL accept_idle cyc=%0d pulse=%h exp=00", cyc, pulse); end
      end
    end
    clr = 8'hFF; irq_en = 8'h00; mode[3:2] = 2'b01;
    @(posedge clk); #1;
    clr = 8'h00;
  endtask

  task automatic test_modes();
    exp_t       e;
    int         e0;
    logic [1:0] mtab [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] m;
    for (int k = 0; k < 4; k++) begin
      m = mtab[k];
      mode[5:4] = m; data[2] = 1'b1;
      e0 = cyc + 1;
      exp_q.push_back('{e0 + 5,  m[0] ? 8'h04 : 8'h00, 8'h04});
      exp_q.push_back('{e0 + 11, m[1] ? 8'h04 : 8'h00, 8'h00});
      repeat (14) begin
        @(posedge clk); #1;
        if (cyc == e0 + 5) data[2] = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          checks++;
          if (pulse !== e.pulse || level !== e.level) begin
            failures++;
            $display("FAIL mode%b_edge cyc=%0d pulse=%h level=%h exp pulse=%h level=%h", m, cyc, pulse, level, e.pulse, e.level);
          end
        end else begin
          checks++;
          if (pulse !== 8'h00) begin failures++; $display("FAIL mode%b_idle cyc=%0d pulse=%h exp=00", m, cyc, pulse); end
        end
      end
    end
    mode[5:4] = 2'b01; clr = 8'hFF;
    @(posedge clk); #1;
    clr = 8'h00;
  endtask

  task automatic test_clr_collide();
    int e0;
    irq_en = 8'h08; data[3] = 1'b1;
    e0 = cyc + 1;
    repeat (9) begin
      @(posedge clk); #1;
      if (cyc == e0 + 5) begin
        checks++; if (pulse !== 8'h08) begin failures++; $display("FAIL collide_pulse got=%h exp=08", pulse); end
        checks++; if (flag !== 8'h08)  begin failures++; $display("FAIL collide_flag got=%h exp=08", flag); end
      end
      if (cyc == e0 + 6) begin
        checks++; if (flag !== 8'h00) begin failures++; $display("FAIL collide_clear got=%h exp=00", flag); end
        checks++; if (irq !== 1'b1)   begin failures++; $display("FAIL collide_irq got=%b exp=1", irq); end
        clr = 8'h00;
      end
      if (cyc == e0 + 7) begin
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL collide_irq_fall got=%b exp=0", irq); end
      end
      if (cyc == e0 + 4) clr = 8'h08;
    end
    irq_en = 8'h00;
  endtask

  // Reset with channel 4 two counts into its filter; both held-high channels
  // must then take a full fresh latency.
  task automatic test_reset_mid();
    exp_t e;
    int   e0;
    data[4] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    #1;
    checks++; if (level !== 8'h00 || pulse !== 8'h00 || flag !== 8'h00 || irq !== 1'b0) begin
      failures++; $display("FAIL midrst_async level=%h pulse=%h flag=%h irq=%b exp all 0", level, pulse, flag, irq);
    end
    #2 n_rst = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back('{e0 + 5, 8'h18, 8'h18});
    repeat (8) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (pulse !== e.pulse || level !== e.level) begin
          failures++;
          $display("FAIL midrst_edge cyc=%0d pulse=%h level=%h exp pulse=%h level=%h", cyc, pulse, level, e.pulse, e.level);
        end
      end else begin
        checks++;
        if (pulse !== 8'h00) begin failures++; $display("FAIL midrst_idle cyc=%0d pulse=%h exp=00", cyc, pulse); end
      end
      if (cyc == e0 + 4) begin
        checks++; if (level !== 8'h00) begin failures++; $display("FAIL midrst_early_level got=%h exp=00", level); end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; data = 8'hFF; mode = {8{2'b01}}; clr = 8'h00; irq_en = 8'h00;
    test_reset();
    test_powerup();
    test_basic();
    test_glitch();
    test_modes();
    test_clr_collide();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
